// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> main-memory line interface.
// Both the cache controller and the responder take LATENCY from here.
package mem_if_pkg;

  localparam int MEM_LATENCY     = 4;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_WORD_W      = 32;
  localparam int DEF_LINE_WORDS  = 4;
  localparam int DEF_DEPTH_LINES = 1024;

  localparam int LINE_BITS = DEF_WORD_W * DEF_LINE_WORDS;
  localparam int OFFSET_W  = $clog2(DEF_WORD_W / 8 * DEF_LINE_WORDS);
  localparam int INDEX_W   = $clog2(DEF_DEPTH_LINES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Byte-offset bits covered by one line; used to strip the offset from addresses.
  function automatic int line_offset_w(input int word_w, input int line_words);
    return $clog2(word_w / 8 * line_words);
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line-wide storage: full-line synchronous write, registered synchronous read.
// Storage is never reset; only the read register is.
module mem_line_array #(
  parameter int DEPTH_LINES = 1024,
  parameter int LINE_BITS   = 128,
  parameter int INDEX_W     = $clog2(DEPTH_LINES)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [INDEX_W-1:0]   i_index,
  input  logic [LINE_BITS-1:0] i_wdata,
  output logic [LINE_BITS-1:0] o_rdata
);

  logic [LINE_BITS-1:0] r_mem [DEPTH_LINES];
  logic [LINE_BITS-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_index] <= i_wdata;
  end

  // Read register holds its value until the next read so fill data stays visible.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_index];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_line_responder.sv
// Main-memory responder: accepts one line request, waits LATENCY cycles,
// performs the access, then pulses resp_valid for one cycle.
module mem_line_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int LATENCY     = MEM_LATENCY,
  parameter int DEPTH_LINES = DEF_DEPTH_LINES
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] req_wdata,
  output logic                         resp_valid,
  output logic [WORD_W*LINE_WORDS-1:0] resp_rdata,
  output logic                         busy
);

  localparam int L_LINE_BITS = WORD_W * LINE_WORDS;
  localparam int L_OFFSET_W  = line_offset_w(WORD_W, LINE_WORDS);
  localparam int L_INDEX_W   = $clog2(DEPTH_LINES);
  localparam int CNT_W       = $clog2(LATENCY) + 1;

  mem_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_resp_valid;
  logic                   r_busy;
  logic [L_INDEX_W-1:0]   r_idx;
  logic                   r_we;
  logic [L_LINE_BITS-1:0] r_wdata;

  logic                   w_access;
  logic                   w_arr_we;
  logic                   w_arr_re;
  logic [ADDR_W-1:0]      w_idx_mask;
  logic                   w_unused_addr;

  // Offset and above-depth address bits are dropped: index wraps modulo DEPTH_LINES.
  assign w_idx_mask    = ADDR_W'(DEPTH_LINES - 1) << L_OFFSET_W;
  assign w_unused_addr = ^(req_addr & ~w_idx_mask);

  assign w_access = (r_state == WAIT) && (r_cnt == CNT_W'(LATENCY));
  assign w_arr_we = w_access && r_we;
  assign w_arr_re = w_access && !r_we;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_idx        <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_idx   <= req_addr[L_OFFSET_W +: L_INDEX_W];
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(LATENCY)) begin
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  mem_line_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .LINE_BITS   (L_LINE_BITS),
    .INDEX_W     (L_INDEX_W)
  ) u_array (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_index (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (resp_rdata)
  );

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: expectations are queued at
// acceptance and checked when resp_valid is observed.
module tb_mem_line_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;
  localparam int LB    = 128;

  logic          clk;
  logic          rst_b;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [LB-1:0] req_wdata;
  logic          resp_valid;
  logic [LB-1:0] resp_rdata;
  logic          busy;

  mem_line_responder #(
    .ADDR_W(32), .WORD_W(32), .LINE_WORDS(4), .LATENCY(LAT), .DEPTH_LINES(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    bit            we;
    int            idx;
    logic [LB-1:0] data;
  } exp_t;

  exp_t          q[$];
  exp_t          m_e;
  logic [LB-1:0] model [int];
  logic [LB-1:0] last_rd = '0;
  int            n_tests = 0;
  int            n_fail  = 0;

  localparam logic [LB-1:0] W_A   = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [LB-1:0] W_AA  = {4{32'hAAAA_AAAA}};
  localparam logic [LB-1:0] W_55  = {4{32'h5555_5555}};
  localparam logic [LB-1:0] W_D0  = {32'hD003, 32'hD002, 32'hD001, 32'hD000};
  localparam logic [LB-1:0] W_D1  = {32'hD103, 32'hD102, 32'hD101, 32'hD100};
  localparam logic [LB-1:0] W_WR  = {32'h0000_0303, 32'h0000_0302, 32'h0000_0301, 32'h0000_0300};
  localparam logic [LB-1:0] W_IC  = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_b) begin
      q.delete();
      last_rd = '0;
    end else begin
      if (resp_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, required no response", cyc);
        end else begin
          m_e = q.pop_front();
          if (cyc != m_e.cyc) begin
            n_fail++;
            $display("FAIL resp_cycle: got cycle %0d, required %0d", cyc, m_e.cyc);
          end else if (m_e.we && resp_rdata !== last_rd) begin
            n_fail++;
            $display("FAIL write_disturb: resp_rdata=%h, required %h", resp_rdata, last_rd);
          end else if (!m_e.we && resp_rdata !== m_e.data) begin
            n_fail++;
            $display("FAIL read_data: idx %0d got %h, required %h", m_e.idx, resp_rdata, m_e.data);
          end
          if (m_e.we) model[m_e.idx] = m_e.data;
          else        last_rd = m_e.data;
        end
      end
      if (req_valid && req_ready) begin
        m_e.cyc = cyc + LAT + 1;
        m_e.we  = req_we;
        m_e.idx = int'(req_addr >> 4) % DEPTH;
        if (req_we)                  m_e.data = req_wdata;
        else if (model.exists(m_e.idx)) m_e.data = model[m_e.idx];
        else                         m_e.data = 'x;
        q.push_back(m_e);
      end
    end
  end

  task automatic send(input bit we, input logic [31:0] addr, input logic [LB-1:0] wd,
                      output int acc);
    acc = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: addr %h never accepted, required acceptance", addr);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (q.size() == 0 && req_ready) done = 1'b1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: %0d responses outstanding, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_tests++;
      if ({req_ready, resp_valid, busy} !== 3'b100 || resp_rdata !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: ready/valid/busy=%b rdata=%h, required 100 and 0",
                 {req_ready, resp_valid, busy}, resp_rdata);
      end
    end
  endtask

  task automatic test_write_read();
    int a;
    send(1'b1, 32'h40, W_A, a);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      n_tests++;
      if ({req_ready, busy, resp_valid} !== {1'b0, 1'b1, (k == LAT + 1)}) begin
        n_fail++;
        $display("FAIL wr_timing: cycle A+%0d ready/busy/valid=%b, required %b",
                 k, {req_ready, busy, resp_valid}, {1'b0, 1'b1, (k == LAT + 1)});
      end
    end
    @(negedge clk);
    n_tests++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL wr_release: ready/busy/valid=%b at A+%0d, required 100",
               {req_ready, busy, resp_valid}, LAT + 2);
    end
    send(1'b0, 32'h4C, '0, a);
    wait_idle();
    n_tests++;
    if (resp_rdata !== W_A) begin
      n_fail++;
      $display("FAIL rd_after_wr: got %h, required %h", resp_rdata, W_A);
    end
  endtask

  task automatic test_back_to_back();
    bit            we_t   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0]   addr_t [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
    logic [LB-1:0] data_t [4] = '{W_D0, W_D1, '0, '0};
    int            accs   [4];
    int            n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we_t[0]; req_addr = addr_t[0]; req_wdata = data_t[0];
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clk);
      if (req_ready) begin
        accs[n] = cyc;
        n++;
        @(posedge clk); #1;
        if (n < 4) begin
          req_we = we_t[n]; req_addr = addr_t[n]; req_wdata = data_t[n];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    n_tests++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL b2b_count: %0d accepted, required 4", n);
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_tests++;
        if (accs[i] - accs[i-1] != LAT + 2) begin
          n_fail++;
          $display("FAIL b2b_spacing: gap %0d, required %0d", accs[i] - accs[i-1], LAT + 2);
        end
      end
    end
    wait_idle();
    n_tests++;
    if (resp_rdata !== W_D1) begin
      n_fail++;
      $display("FAIL b2b_last_read: got %h, required %h", resp_rdata, W_D1);
    end
  endtask

  task automatic test_wrap();
    int a;
    send(1'b1, 32'((DEPTH + 3) << 4), W_WR, a);
    wait_idle();
    send(1'b0, 32'(3 << 4), '0, a);
    wait_idle();
    n_tests++;
    if (resp_rdata !== W_WR) begin
      n_fail++;
      $display("FAIL wrap_read: got %h, required %h", resp_rdata, W_WR);
    end
  endtask

  task automatic test_reset_abort();
    int a;
    send(1'b1, 32'h80, W_AA, a);
    wait_idle();
    send(1'b1, 32'h80, W_55, a);
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, busy, resp_valid} !== 3'b100 || resp_rdata !== '0) begin
      n_fail++;
      $display("FAIL abort_async: ready/busy/valid=%b rdata=%h, required 100 and 0",
               {req_ready, busy, resp_valid}, resp_rdata);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_resp: resp_valid=%b, required 0", resp_valid);
      end
    end
    send(1'b0, 32'h80, '0, a);
    wait_idle();
    n_tests++;
    if (resp_rdata !== W_AA) begin
      n_fail++;
      $display("FAIL abort_no_commit: got %h, required %h", resp_rdata, W_AA);
    end
  endtask

  task automatic test_input_change();
    int a;
    send(1'b1, 32'h300, W_IC, a);
    req_addr = 32'h400; req_wdata = ~W_IC; req_we = 1'b0;
    wait_idle();
    send(1'b0, 32'h300, '0, a);
    req_addr = 32'h40; req_we = 1'b1; req_wdata = ~W_IC;
    wait_idle();
    n_tests++;
    if (resp_rdata !== W_IC) begin
      n_fail++;
      $display("FAIL input_change: got %h, required %h", resp_rdata, W_IC);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    test_input_change();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
